// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan driver.
// Segment patterns are active-low in {g,f,e,d,c,b,a} order.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEAD  = 2'd1,
    DRIVE = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam int unsigned DEAD_CYCLES_DEFAULT = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] ANODES_OFF  = 4'b1111;
  localparam logic [3:0] PHASE_FIRST = 4'b0001;
  localparam logic [3:0] PHASE_LAST  = 4'b1000;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Only meaningful for a one-hot input; anything else maps to digit 0.
  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    case (v)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment pattern.
// Non-decimal values 10..15 render as a centre dash.
module bcd_to_seg7
  import seg_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit common-anode scan driver following a one-hot ring counter, with
// dead-time insertion, frame-synchronous data commit, blanking and fault latch.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = DEAD_CYCLES_DEFAULT
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [3:0]  Phase,
  input  logic [15:0] Digit_data,
  input  logic        Load,
  input  logic        Blank_lead,
  output logic [3:0]  Anode_n,
  output logic [6:0]  Seg_n,
  output logic        Phase_err,
  output logic        Frame_done,
  output logic        Load_ack
);

  localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  phase_q;
  logic [15:0] staging_q, staging_d;
  logic [15:0] shadow_q, shadow_d;
  logic        pending_q, pending_d;

  logic [3:0]  anode_d;
  logic [6:0]  seg_d;
  logic        err_d;
  logic        frame_d;
  logic        ack_d;

  logic        phase_valid;
  logic        phase_change;
  logic        boundary;
  logic        commit;

  logic [1:0]  digit_sel;
  logic [3:0]  nibble;
  logic        lead_blank;
  logic [6:0]  dec_seg;
  logic [6:0]  drive_seg;

  assign phase_valid  = is_onehot(Phase);
  assign phase_change = (Phase != phase_q);
  assign boundary     = (state_q != FAULT) && (phase_q == PHASE_LAST) &&
                        (Phase == PHASE_FIRST);
  assign commit       = boundary && pending_q;

  // Digit selection follows the registered phase, which equals the live
  // phase whenever the FSM is about to enter DRIVE.
  assign digit_sel = onehot_index(phase_q);
  assign nibble    = shadow_q[{digit_sel, 2'b00} +: 4];

  always_comb begin
    case (digit_sel)
      2'd1:    lead_blank = (shadow_q[15:4] == 12'd0);
      2'd2:    lead_blank = (shadow_q[15:8] == 8'd0);
      2'd3:    lead_blank = (shadow_q[15:12] == 4'd0);
      default: lead_blank = 1'b0;
    endcase
  end

  bcd_to_seg7 u_decode (
    .bcd (nibble),
    .seg (dec_seg)
  );

  assign drive_seg = (Blank_lead && lead_blank) ? SEG_BLANK : dec_seg;

  // Scan FSM: an invalid phase wins over everything and is terminal.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!phase_valid) begin
      state_d = FAULT;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = DEAD;
          cnt_d   = DEAD_LOAD;
        end
        DEAD: begin
          if (phase_change) begin
            cnt_d = DEAD_LOAD;
          end else if (cnt_q == 8'd0) begin
            state_d = DRIVE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        DRIVE: begin
          if (phase_change) begin
            state_d = DEAD;
            cnt_d   = DEAD_LOAD;
          end
        end
        default: state_d = FAULT;
      endcase
    end
  end

  // Outputs are computed from the next state and registered; segments are
  // latched on DRIVE entry so they cannot move while an anode is lit.
  always_comb begin
    anode_d = ANODES_OFF;
    seg_d   = SEG_BLANK;
    if (state_d == DRIVE) begin
      anode_d = ~phase_q;
      seg_d   = (state_q == DRIVE) ? Seg_n : drive_seg;
    end
    err_d   = (state_d == FAULT);
    frame_d = boundary;
    ack_d   = commit;
  end

  // Staging takes the newest Load; shadow only moves at a frame wrap.
  always_comb begin
    staging_d = Load ? Digit_data : staging_q;
    shadow_d  = commit ? staging_q : shadow_q;
    pending_d = commit ? Load : (pending_q | Load);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      phase_q    <= 4'b0000;
      // NOTE: the data registers are reset too, so a fresh display never
      // shows stale digits from before the reset.
      staging_q  <= 16'd0;
      shadow_q   <= 16'd0;
      pending_q  <= 1'b0;
      Anode_n    <= ANODES_OFF;
      Seg_n      <= SEG_BLANK;
      Phase_err  <= 1'b0;
      Frame_done <= 1'b0;
      Load_ack   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= Phase;
      staging_q  <= staging_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      Anode_n    <= anode_d;
      Seg_n      <= seg_d;
      Phase_err  <= err_d;
      Frame_done <= frame_d;
      Load_ack   <= ack_d;
    end
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Multiplexed 4-digit seven-segment display driver that sits directly downstream of the 4-bit one-hot ring counter. It consumes the ring counter's one-hot phase as the digit select and drives common-anode digits with dead-time insertion, tear-free frame-synchronous data updates, leading-zero blanking and one-hot fault detection.

## Interface
- DEAD_CYCLES, default 4: anode-off gap in clock cycles after every phase change. Legal range is 1..255.
- Clock  in  1  system clock; all logic updates on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- Phase  in  4  one-hot digit select from the ring counter; bit i selects digit i (digit 0 is rightmost).
- Digit_data  in  16  BCD digits; nibble [4i+3:4i] belongs to digit i.
- Load  in  1  one-cycle request to capture Digit_data for display.
- Blank_lead  in  1  enables leading-zero blanking.
- Anode_n  out  4  active-low digit enables.
- Seg_n  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- Phase_err  out  1  sticky fault flag.
- Frame_done  out  1  one-cycle pulse at each 1000→0001 wrap.
- Load_ack  out  1  one-cycle pulse when staged data reaches the display.

## Operation
**Reset values (Reset=0 at an edge):** Anode_n=1111, Seg_n=1111111, Phase_err=0, Frame_done=0, Load_ack=0; staging, shadow and pending cleared; phase_q=0000; state IDLE.

**Registers**
- phase_q: the last sampled Phase.
- A change is detected when Phase != phase_q.
- Valid means exactly one bit of Phase is set.

**FSM states**
- IDLE: anodes off. A valid Phase moves to DEAD.
- DEAD: anodes and segments off; the down-counter is loaded with DEAD_CYCLES-1. Moves to DRIVE when the counter is 0.
- DRIVE: Anode_n=~phase_q; Seg_n is the decode of the shadow nibble selected by phase_q. A valid change moves to DEAD.
- FAULT: anodes off, Phase_err=1. Entered from any state when an invalid Phase is sampled (0000 or more than one bit set). Left only by reset.

**Phase handling**
- A valid but non-adjacent change (e.g. 0001→0100) is handled as a normal change.
- A change during DEAD restarts the dead counter.

**Data path**
- Load=1 copies Digit_data into staging and sets pending. A Load while pending is already set overwrites staging.
- Frame boundary: phase_q=1000 and Phase=0001. At that edge:
  - Frame_done is set for one cycle.
  - If pending: shadow ← staging, pending is cleared, Load_ack is set for one cycle.
- Load and a frame boundary in the same cycle: the old staging is committed to shadow, the new data lands in staging, and pending stays 1.

**Decode (active-low gfedcba)**
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- 10–15 show a dash: 0111111.
- Blanking: when Blank_lead=1, digit i≥1 shows 1111111 if nibble i and every higher nibble are 0. Digit 0 is never blanked.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- A phase change sampled at edge t:
  - Anode_n=1111 from edge t for exactly DEAD_CYCLES cycles.
  - The new digit is driven from edge t+DEAD_CYCLES.
- Invalid Phase sampled at edge t: Phase_err=1 and Anode_n=1111 from edge t.
- Frame_done and Load_ack are high for the single cycle after the boundary edge.
- Reset mid-frame or in FAULT: all values return to reset values on the next edge, and Phase_err is cleared.
- Segment and anode updates are simultaneous; segments never change while an anode is on.

## Structure
- Package seg_scan_pkg holds:
  - the state enum {IDLE, DEAD, DRIVE, FAULT};
  - the segment-pattern constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK;
  - the default DEAD_CYCLES.
- Sub-module bcd_to_seg7: combinational nibble-to-pattern decode (4-bit in, 7-bit out).
- The top level instantiates one bcd_to_seg7 fed by a nibble mux.

## Test plan
- Reset, then Phase=0001 with shadow=0; DEAD_CYCLES=4 → Anode_n=1111 for 4 cycles, then Anode_n=1110, Seg_n=1000000.
- Load 0x0420 with Blank_lead=1, then rotate through a full frame → Load_ack pulses once at the 1000→0001 wrap; digit3 blank, digit2=0011001, digit1=0100100, digit0=1000000.
- Load asserted in the boundary cycle with new data 0x1234 while 0x0420 is pending → 0x0420 displays this frame, 0x1234 displays after the next wrap, with one Load_ack per commit.
- Phase=0110 mid-DRIVE → from that edge Anode_n=1111 and Phase_err=1; it stays set under further valid phases until Reset=0.
- Nibble value 0xB on digit 1 → Seg_n=0111111 when Phase=0010.
- Reset asserted during DEAD → all outputs at reset values on the next edge; the FSM returns to IDLE.
